lvt_ram_2w2r: RTL
=================

Name: lvt_ram_2w2r

Overview:
- Two-write, two-read RAM built from four 1W1R banks.
- Write port A updates banks A0 and A1; write port B updates banks B0 and B1.
- An internal live-value table (LVT) records, per address, which write port last wrote it. Each read port uses the LVT to pick the bank A or bank B word.
- Fabric-level shared storage for dual-issue pipelines and multi-producer lookup tables.

Parameters:
- ADDR_WIDTH, 4, address bits per port.
- DATA_WIDTH, 16, word width.
- NUM_WORDS, 1 << ADDR_WIDTH, depth; derived, not overridden.

Ports:
- clk  input  1  single clock, all logic posedge.
- rst  input  1  reset, synchronous, active-high.
- waddr_a  input  ADDR_WIDTH  write port A address.
- wdata_a  input  DATA_WIDTH  write port A data.
- we_a  input  1  write port A enable.
- waddr_b  input  ADDR_WIDTH  write port B address.
- wdata_b  input  DATA_WIDTH  write port B data.
- we_b  input  1  write port B enable.
- raddr_a  input  ADDR_WIDTH  read port A address.
- re_a  input  1  read port A request.
- raddr_b  input  ADDR_WIDTH  read port B address.
- re_b  input  1  read port B request.
- rdata_a  output  DATA_WIDTH  read port A data.
- rvalid_a  output  1  rdata_a valid strobe.
- rdata_b  output  DATA_WIDTH  read port B data.
- rvalid_b  output  1  rdata_b valid strobe.

Behaviour:
- Stage 0, input register: all address, data and enable inputs are registered every cycle (edge e1).
- Stage 1, commit and read (edge e2):
  - Registered writes go to their two banks.
  - LVT flag[waddr] is cleared to 0 for port A and set to 1 for port B.
  - Both read ports read their bank pair and the LVT flag from registered addresses.
- Stage 2, output mux (edge e3): rdata_x is the bank B word if the flag is 1, else the bank A word. rvalid_x equals re_x delayed three cycles.
- Read latency: re_x and raddr_x in cycle M give rdata_x/rvalid_x in cycle M+3. Fully pipelined, one read per port per cycle.
- Read-during-write ordering:
  - A read presented in the same cycle as a write to that address returns the old word.
  - A read presented one or more cycles after the write returns the new word.
  - Banks use old-data read-during-write mode.
- Write contest: we_a and we_b to the same address in the same cycle → port B wins. The flag is 1 and subsequent reads return wdata_b.
- Different-address simultaneous writes: both take effect, no interaction.
- rdata_x when rvalid_x=0: don't-care. The mux still drives bank data; the verification engineer must not check it.
- Reset (rst=1 sampled at a posedge):
  - Registered we_a/we_b and the re pipeline are cleared; writes presented while rst=1 are dropped.
  - All LVT flags clear to 0 (bank A).
  - rvalid_a=rvalid_b=0 from the cycle after rst is sampled; rdata_x reset to 0.
  - Bank contents are not reset. Reads of addresses not written since reset return undefined data.
- Reset mid-operation:
  - Reads in flight are dropped; no rvalid is produced for them.
  - A write already registered at the rst edge is suppressed.
- Address wrap: no wrap logic; full ADDR_WIDTH range is valid. NUM_WORDS-1 and 0 are independent entries.
- LVT is implemented as NUM_WORDS flops, not RAM, because it needs two write ports.

Decomposition:
- Shared package holds:
  - LVT_SEL_A=1'b0 and LVT_SEL_B=1'b1 constants.
  - The read-latency constant RD_LATENCY=3, used by both RTL and bench.
- Natural sub-module: simple_dual_port_ram, 1W1R, registered read, old-data mode, parameters ADDR_WIDTH/DATA_WIDTH.
  - Instantiated four times (A0, A1, B0, B1).
- The LVT and output mux stay in the top level.

Test Plan:
- Single writes: write A addr 3=0x1111, later write B addr 5=0x2222, then read A@3 and B@5 → rdata_a=0x1111, rdata_b=0x2222, rvalid 3 cycles after re.
- Overwrite by other port: A writes addr 7=0xAAAA, then B writes addr 7=0xBBBB, then both ports read 7 → both return 0xBBBB. Then A writes 7=0xCCCC → both read 0xCCCC.
- Contest: same cycle A writes addr 2=0x0A0A and B writes addr 2=0x0B0B → later reads of 2 return 0x0B0B on both ports.
- Read-during-write: addr 9 holds 0x1234; write A 9=0x5678 with read 9 in the same cycle → 0x1234. Read the next cycle → 0x5678.
- Throughput: back-to-back reads of addrs 0..15 on both ports every cycle after filling → 16 consecutive rvalid pulses with matching data, no gaps.
- Reset mid-operation: issue 3 reads, assert rst one cycle → no rvalid for those reads. After reset, write B addr 4=0x4444, read 4 → 0x4444. LVT flag for an unwritten address reads bank A (sel 0).

Source files
------------

// File: rtl/lvt_ram_2w2r_pkg.sv
// Shared constants for the two-write/two-read LVT RAM: bank-select encoding
// and the end-to-end read latency seen at the ports.
package lvt_ram_2w2r_pkg;
  localparam logic LVT_SEL_A  = 1'b0;
  localparam logic LVT_SEL_B  = 1'b1;
  localparam int   RD_LATENCY = 3;
endpackage

// File: rtl/lvt_ram_2w2r_if.sv
// Port bundle for lvt_ram_2w2r: two write ports and two read ports.
interface lvt_ram_2w2r_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] waddr_a;
  logic [DATA_WIDTH-1:0] wdata_a;
  logic                  we_a;
  logic [ADDR_WIDTH-1:0] waddr_b;
  logic [DATA_WIDTH-1:0] wdata_b;
  logic                  we_b;
  logic [ADDR_WIDTH-1:0] raddr_a;
  logic                  re_a;
  logic [ADDR_WIDTH-1:0] raddr_b;
  logic                  re_b;
  logic [DATA_WIDTH-1:0] rdata_a;
  logic                  rvalid_a;
  logic [DATA_WIDTH-1:0] rdata_b;
  logic                  rvalid_b;

  modport master (
    output waddr_a, wdata_a, we_a, waddr_b, wdata_b, we_b,
    output raddr_a, re_a, raddr_b, re_b,
    input  rdata_a, rvalid_a, rdata_b, rvalid_b
  );

  modport slave (
    input  waddr_a, wdata_a, we_a, waddr_b, wdata_b, we_b,
    input  raddr_a, re_a, raddr_b, re_b,
    output rdata_a, rvalid_a, rdata_b, rvalid_b
  );
endinterface

// File: rtl/lvt_ram_2w2r_sdp.sv
// 1W1R RAM bank with registered read; a same-edge read of the written
// address returns the previous word.
module simple_dual_port_ram
  import lvt_ram_2w2r_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int NUM_WORDS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_comb begin
    rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/lvt_ram_2w2r.sv
// Two-write/two-read RAM: each write port owns a bank pair, and a flop-based
// live-value table picks, per address, the pair holding the latest word.
module lvt_ram_2w2r
  import lvt_ram_2w2r_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  lvt_ram_2w2r_if.slave bus
);
  localparam int NUM_WORDS = 1 << ADDR_WIDTH;

  // Stage 0: register every input
  logic [ADDR_WIDTH-1:0] waddr_a_p0_d, waddr_a_p0_q;
  logic [ADDR_WIDTH-1:0] waddr_b_p0_d, waddr_b_p0_q;
  logic [DATA_WIDTH-1:0] wdata_a_p0_d, wdata_a_p0_q;
  logic [DATA_WIDTH-1:0] wdata_b_p0_d, wdata_b_p0_q;
  logic [ADDR_WIDTH-1:0] raddr_a_p0_d, raddr_a_p0_q;
  logic [ADDR_WIDTH-1:0] raddr_b_p0_d, raddr_b_p0_q;
  logic                  we_a_p0_d, we_a_p0_q;
  logic                  we_b_p0_d, we_b_p0_q;
  logic [RD_LATENCY-1:0] vld_a_d, vld_a_q;
  logic [RD_LATENCY-1:0] vld_b_d, vld_b_q;

  always_comb begin
    waddr_a_p0_d = bus.waddr_a;
    waddr_b_p0_d = bus.waddr_b;
    wdata_a_p0_d = bus.wdata_a;
    wdata_b_p0_d = bus.wdata_b;
    raddr_a_p0_d = bus.raddr_a;
    raddr_b_p0_d = bus.raddr_b;
    we_a_p0_d    = bus.we_a;
    we_b_p0_d    = bus.we_b;
    vld_a_d      = {vld_a_q[RD_LATENCY-2:0], bus.re_a};
    vld_b_d      = {vld_b_q[RD_LATENCY-2:0], bus.re_b};
  end

  always_ff @(posedge clk) begin
    waddr_a_p0_q <= waddr_a_p0_d;
    waddr_b_p0_q <= waddr_b_p0_d;
    wdata_a_p0_q <= wdata_a_p0_d;
    wdata_b_p0_q <= wdata_b_p0_d;
    raddr_a_p0_q <= raddr_a_p0_d;
    raddr_b_p0_q <= raddr_b_p0_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_a_p0_q <= 1'b0;
      we_b_p0_q <= 1'b0;
      vld_a_q   <= '0;
      vld_b_q   <= '0;
    end else begin
      we_a_p0_q <= we_a_p0_d;
      we_b_p0_q <= we_b_p0_d;
      vld_a_q   <= vld_a_d;
      vld_b_q   <= vld_b_d;
    end
  end

  // Stage 1: commit writes, read banks and LVT
  logic                  cm_we_a, cm_we_b;
  logic [NUM_WORDS-1:0]  lvt_d, lvt_q;
  logic                  sel_a_p1_d, sel_a_p1_q;
  logic                  sel_b_p1_d, sel_b_p1_q;
  logic [DATA_WIDTH-1:0] rd_a0_p1, rd_a1_p1, rd_b0_p1, rd_b1_p1;

  // A write already registered when reset arrives must not commit.
  assign cm_we_a = we_a_p0_q & ~rst;
  assign cm_we_b = we_b_p0_q & ~rst;

  always_comb begin
    lvt_d = lvt_q;
    if (cm_we_a) lvt_d[waddr_a_p0_q] = LVT_SEL_A;
    if (cm_we_b) lvt_d[waddr_b_p0_q] = LVT_SEL_B;
    sel_a_p1_d = lvt_q[raddr_a_p0_q];
    sel_b_p1_d = lvt_q[raddr_b_p0_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvt_q <= {NUM_WORDS{LVT_SEL_A}};
    end else begin
      lvt_q <= lvt_d;
    end
    sel_a_p1_q <= sel_a_p1_d;
    sel_b_p1_q <= sel_b_p1_d;
  end

  simple_dual_port_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_bank_a0 (
    .clk(clk), .we(cm_we_a), .waddr(waddr_a_p0_q), .wdata(wdata_a_p0_q),
    .raddr(raddr_a_p0_q), .rdata(rd_a0_p1)
  );
  simple_dual_port_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_bank_a1 (
    .clk(clk), .we(cm_we_a), .waddr(waddr_a_p0_q), .wdata(wdata_a_p0_q),
    .raddr(raddr_b_p0_q), .rdata(rd_a1_p1)
  );
  simple_dual_port_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_bank_b0 (
    .clk(clk), .we(cm_we_b), .waddr(waddr_b_p0_q), .wdata(wdata_b_p0_q),
    .raddr(raddr_a_p0_q), .rdata(rd_b0_p1)
  );
  simple_dual_port_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_bank_b1 (
    .clk(clk), .we(cm_we_b), .waddr(waddr_b_p0_q), .wdata(wdata_b_p0_q),
    .raddr(raddr_b_p0_q), .rdata(rd_b1_p1)
  );

  // Stage 2: LVT-steered output mux
  logic [DATA_WIDTH-1:0] rdata_a_d, rdata_a_q;
  logic [DATA_WIDTH-1:0] rdata_b_d, rdata_b_q;

  always_comb begin
    rdata_a_d = (sel_a_p1_q == LVT_SEL_B) ? rd_b0_p1 : rd_a0_p1;
    rdata_b_d = (sel_b_p1_q == LVT_SEL_B) ? rd_b1_p1 : rd_a1_p1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign bus.rdata_a  = rdata_a_q;
  assign bus.rdata_b  = rdata_b_q;
  assign bus.rvalid_a = vld_a_q[RD_LATENCY-1];
  assign bus.rvalid_b = vld_b_q[RD_LATENCY-1];
endmodule
